muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M operation set for the multi-cycle RISC-V core; generalises to XLEN and a configurable number of result bits per iteration.
- Sits beside the ALU. The control FSM issues start with funct3 and the two register operands (register_output_A, WriteData), stalls while busy, and routes result onto the Result bus on done.

---
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// BITS_PER_CYCLE result bits per iteration, with sign fix-up and divide special cases.
module muldiv_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q, b_q, babs_q, hi_q, lo_q, result_q;
  logic [CW-1:0]     cnt_q;
  logic              accept;

  // Accept-time special cases: divide by zero and signed overflow skip iteration.
  logic            div_zero, div_ovf, spec_hit;
  logic [XLEN-1:0] spec_res;
  assign div_zero = (b == '0);
  assign div_ovf  = ~funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign spec_hit = funct3[2] && (div_zero || div_ovf);
  assign spec_res = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  assign a_signed = ~(op_q[0] & (op_q[1] | op_q[2]));
  assign b_signed = a_signed & (op_q != 3'b010);
  assign a_neg    = a_signed & a_q[XLEN-1];
  assign b_neg    = b_signed & b_q[XLEN-1];
  assign a_abs    = a_neg ? -a_q : a_q;
  assign b_abs    = b_neg ? -b_q : b_q;

  // One iteration: BITS_PER_CYCLE shift-add or restoring-subtract steps on {hi, lo}.
  logic [XLEN-1:0] hi_n, lo_n;
  logic [XLEN:0]   sum, rem_sh, diff;
  always_comb begin
    hi_n   = hi_q;
    lo_n   = lo_q;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!op_q[2]) begin
        sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, babs_q} : '0);
        hi_n = sum[XLEN:1];
        lo_n = {sum[0], lo_n[XLEN-1:1]};
      end else begin
        rem_sh = {hi_n, lo_n[XLEN-1]};
        diff   = rem_sh - {1'b0, babs_q};
        hi_n   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        lo_n   = {lo_n[XLEN-2:0], ~diff[XLEN]};
      end
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  assign prod     = {hi_q, lo_q};
  assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;
  assign quo_fix  = (a_neg ^ b_neg) ? -lo_q : lo_q;
  assign rem_fix  = a_neg ? -hi_q : hi_q;

  always_comb begin
    fix_res = '0;
    unique case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = spec_hit ? StDone : StPrep;
        end
      end
      StPrep:  state_d = StRun;
      StRun:   if (cnt_q == '0) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill && (state_q inside {StPrep, StRun, StFix})) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      babs_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q <= funct3;
        a_q  <= a;
        b_q  <= b;
        if (spec_hit) result_q <= spec_res;
      end
      if (state_q == StPrep) begin
        hi_q   <= '0;
        lo_q   <= a_abs;
        babs_q <= b_abs;
        cnt_q  <= CW'(N - 1);
      end
      if (state_q == StRun) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q - CW'(1);
      end
      if (state_q == StFix && !kill) result_q <= fix_res;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, kill/ignore/reset
// sequences and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int XLEN = 32;
  localparam int N    = 32;

  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_result = '0;

  muldiv_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy, ux, uy, p;
    logic [31:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    p  = '0;
    r  = '0;
    case (op)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] x,
                                    input logic [31:0] y);
    return op[2] && ((y == 0) || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op in the current cycle; optionally pulses a competing start at edge 5.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input bit intrude);
    int          edges;
    int          lat;
    logic [31:0] exp;
    exp    = model(op, x, y);
    lat    = is_special(op, x, y) ? 1 : N + 3;
    funct3 = op;
    a      = x;
    b      = y;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (edges < lat + 5 && !done) begin
      check("busy_run", busy, 1);
      start = intrude && (edges == 4);
      if (start) begin
        funct3 = ~op;
        a      = $urandom;
        b      = $urandom;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", edges, lat);
    check("busy_done", busy, 1);
    check($sformatf("result op%0d %h %h", op, x, y), result, exp);
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("result_held", result, exp);
    last_result = exp;
  endtask

  initial begin
    int          edges;
    logic [2:0]  op;
    logic [31:0] x, y;

    reset  = 1'b1;
    start  = 1'b0;
    kill   = 1'b0;
    funct3 = '0;
    a      = '0;
    b      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("mul_neg", result, 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mulh_min", result, 32'h4000_0000);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulhu_max", result, 32'hFFFF_FFFE);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check("mulhsu", result, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd100, 32'd0, 1'b0);
    check("divu_zero", result, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd100, 32'd0, 1'b0);
    check("remu_zero", result, 32'd100);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf", result, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("rem_ovf", result, 32'd0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("rem_neg", result, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg", result, 32'hFFFF_FFFD);

    // DIVU 1000/7 with an ignored start at edge 5 and kill at edge 10.
    funct3 = 3'd5;
    a      = 32'd1000;
    b      = 32'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (edges < 10) begin
      start = (edges == 4);
      if (start) begin
        funct3 = 3'd0;
        a      = 32'd5;
        b      = 32'd3;
      end
      kill = (edges == 9);
      @(posedge clk);
      #1;
      edges++;
      check("kill_nodone", done, 0);
    end
    start = 1'b0;
    kill  = 1'b0;
    check("kill_busy", busy, 0);
    check("kill_result", result, last_result);
    repeat (40) begin
      @(posedge clk);
      #1;
      check("kill_quiet", done, 0);
    end

    run_op(3'd5, 32'd1000, 32'd7, 1'b1);
    check("retry_divu", result, 32'd142);

    // Kill while idle is a no-op.
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_idle", busy, 0);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: y = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(op, x, y, 1'b0);
    end

    // Reset mid-RUN clears result and busy.
    funct3 = 3'd0;
    a      = $urandom;
    b      = $urandom;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("run_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_result", result, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
